times_table_writer: RTL and testbench

- Writer/loader for the 0..7 x 0..7 times-table memory that the table-lookup multiplier reads.
- On `start`, it sweeps every {a,b} address and writes a*b through a ready/valid write port.
- Products are computed by running addition, not a multiplier.
- Optionally reads the table back, checks every entry and reports the first mismatch. Sits between the control logic and the table RAM at power-up.

---
 rtl/tt_pkg.sv | 8 +
 rtl/tt_addr_gen.sv | 30 +++
 rtl/times_table_writer.sv | 75 +++++++
 tb/tb_times_table_writer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// tt_pkg: shared constants and FSM state type for the times-table writer.
package tt_pkg;
  localparam int TT_A_W = 3;
  localparam int TT_DEPTH = 1 << (2 * TT_A_W);
  localparam int TT_LAST = TT_DEPTH - 1;
  localparam int TT_MAX_PRODUCT = ((1 << TT_A_W) - 1) * ((1 << TT_A_W) - 1);
  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_VERIFY, ST_FLUSH, ST_DONE} tt_state_e;
endpackage

// File: rtl/tt_addr_gen.sv
// tt_addr_gen: {a,b} sweep counter with a running sum acc that always equals a*b.
module tt_addr_gen
  import tt_pkg::*;
#(
  parameter int A_W = TT_A_W,
  parameter int DATA_W = 2 * A_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [2*A_W-1:0]  addr,
  output logic [DATA_W-1:0] acc,
  output logic              last
);
  logic [A_W-1:0] a, b;
  assign addr = {a, b};
  assign last = &addr;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      a <= '0;
      b <= '0;
      acc <= '0;
    end else if (advance) begin
      b <= b + 1'b1;
      a <= (&b) ? a + 1'b1 : a;
      acc <= (&b) ? '0 : acc + DATA_W'(a);
    end
  end
endmodule

// File: rtl/times_table_writer.sv
// times_table_writer: loads a*b into the times-table RAM and optionally reads it back to check it.
module times_table_writer
  import tt_pkg::*;
#(
  parameter int A_W = TT_A_W,
  parameter int DATA_W = 2 * A_W,
  parameter bit VERIFY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [2*A_W-1:0]  mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              error,
  output logic [2*A_W-1:0]  err_addr
);
  tt_state_e state, state_n;
  logic clear, advance, last, cmp_v;
  logic [DATA_W-1:0] exp_d;
  logic [2*A_W-1:0] exp_a;
  assign clear = (state == ST_IDLE) && start;
  assign advance = ((state == ST_WRITE) && mem_ready) || (state == ST_VERIFY);
  // the counter wraps to {0,0}/acc=0 after the last write, so VERIFY starts clean
  tt_addr_gen #(.A_W(A_W), .DATA_W(DATA_W)) gen (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .advance(advance),
    .addr(mem_addr),
    .acc(mem_wdata),
    .last(last)
  );
  always_comb begin
    state_n = (state == ST_IDLE)   ? (start ? ST_WRITE : ST_IDLE) :
              (state == ST_WRITE)  ? ((mem_ready && last) ? (VERIFY ? ST_VERIFY : ST_DONE) : ST_WRITE) :
              (state == ST_VERIFY) ? (last ? ST_FLUSH : ST_VERIFY) :
              (state == ST_FLUSH)  ? ST_DONE : ST_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      error <= 1'b0;
      err_addr <= '0;
      cmp_v <= 1'b0;
      exp_d <= '0;
      exp_a <= '0;
    end else begin
      state <= state_n;
      busy <= (state_n == ST_WRITE) || (state_n == ST_VERIFY) || (state_n == ST_FLUSH);
      done <= state_n == ST_DONE;
      mem_we <= state_n == ST_WRITE;
      mem_re <= state_n == ST_VERIFY;
      cmp_v <= mem_re;
      exp_d <= mem_wdata;
      exp_a <= mem_addr;
      if (clear) begin
        error <= 1'b0;
        err_addr <= '0;
      end else if (cmp_v && (mem_rdata != exp_d) && !error) begin
        error <= 1'b1;
        err_addr <= exp_a;
      end
    end
  end
endmodule

// File: tb/tb_times_table_writer.sv
// tb_times_table_writer: drives a write-only and a verifying writer against a behavioural RAM and scoreboard.
module tb_times_table_writer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start [2];
  logic busy [2];
  logic done [2];
  logic we [2];
  logic ready [2];
  logic re [2];
  logic error [2];
  logic [5:0] addr [2];
  logic [5:0] wdata [2];
  logic [5:0] rdata [2];
  logic [5:0] err_addr [2];
  always #5 clk = ~clk;

  times_table_writer #(.VERIFY(0)) u0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
    .mem_addr(addr[0]), .mem_we(we[0]), .mem_wdata(wdata[0]), .mem_ready(ready[0]),
    .mem_re(re[0]), .mem_rdata(rdata[0]), .error(error[0]), .err_addr(err_addr[0])
  );
  times_table_writer #(.VERIFY(1)) u1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
    .mem_addr(addr[1]), .mem_we(we[1]), .mem_wdata(wdata[1]), .mem_ready(ready[1]),
    .mem_re(re[1]), .mem_rdata(rdata[1]), .error(error[1]), .err_addr(err_addr[1])
  );

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int ph = 0;
  int s [2];
  int wr_n [2];
  int rd_n [2];
  int done_n [2];
  int done_rel [2];
  bit act [2];
  bit rmode [2];
  bit pstall [2];
  bit prd_v [2];
  bit exp_err [2];
  logic [5:0] paddr [2];
  logic [5:0] pwdata [2];
  logic [5:0] prd_a [2];
  logic [5:0] exp_ea [2];
  logic [63:0] corrupt [2];
  logic [5:0] ram [2][64];

  function automatic void chk(int i, string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL u%0d %s at cycle %0d: got %0d expected %0d", i, name, ncyc, got, want);
    end
  endfunction

  // memory side: ready pattern and read data one cycle after each read request
  initial begin
    for (int i = 0; i < 2; i++) begin
      ready[i] = 1'b1;
      rdata[i] = 6'd0;
    end
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        ready[i] = rmode[i] ? (ph % 3 == 0) : 1'b1;
        rdata[i] = prd_v[i] ? (ram[i][prd_a[i]] ^ (corrupt[i][prd_a[i]] ? 6'd7 : 6'd0)) : 6'd0;
      end
      ph++;
    end
  end

  // scoreboard: every output checked on every falling edge
  initial begin
    int rel;
    forever begin
      @(negedge clk);
      ncyc++;
      for (int i = 0; i < 2; i++) begin
        rel = ncyc - s[i] + 1;
        if (!act[i]) begin
          chk(i, "idle we", we[i], 0);
          chk(i, "idle re", re[i], 0);
          chk(i, "idle busy", busy[i], 0);
          chk(i, "idle done", done[i], 0);
        end else begin
          if (rel == 1) begin
            chk(i, "error cleared", error[i], 0);
            chk(i, "err_addr cleared", err_addr[i], 0);
          end
          if (pstall[i]) begin
            chk(i, "stall we", we[i], 1);
            chk(i, "stall addr", addr[i], paddr[i]);
            chk(i, "stall wdata", wdata[i], pwdata[i]);
          end
          if (we[i]) begin
            chk(i, "write addr", addr[i], wr_n[i]);
            chk(i, "product", wdata[i], int'(addr[i][5:3]) * int'(addr[i][2:0]));
            if (ready[i]) begin
              if (addr[i] == 6'h2B) chk(i, "entry 0x2B", wdata[i], 15);
              if (addr[i] == 6'h3F) chk(i, "entry 0x3F", wdata[i], 49);
              if (addr[i] < 6'd8) chk(i, "row 0 entry", wdata[i], 0);
              ram[i][addr[i]] = wdata[i];
              wr_n[i]++;
            end
          end
          if (re[i]) begin
            chk(i, "read addr", addr[i], rd_n[i]);
            chk(i, "we during read", we[i], 0);
            rd_n[i]++;
          end
          if (done[i]) begin
            done_n[i]++;
            done_rel[i] = rel;
            act[i] = 1'b0;
            chk(i, "done we", we[i], 0);
            chk(i, "done re", re[i], 0);
            chk(i, "done busy", busy[i], 0);
          end else chk(i, "busy", busy[i], 1);
        end
        pstall[i] = we[i] && !ready[i];
        paddr[i] = addr[i];
        pwdata[i] = wdata[i];
        prd_v[i] = re[i];
        prd_a[i] = addr[i];
      end
    end
  end

  task automatic check_idle(int i);
    chk(i, "reset busy", busy[i], 0);
    chk(i, "reset done", done[i], 0);
    chk(i, "reset we", we[i], 0);
    chk(i, "reset re", re[i], 0);
    chk(i, "reset error", error[i], 0);
    chk(i, "reset addr", addr[i], 0);
    chk(i, "reset wdata", wdata[i], 0);
    chk(i, "reset err_addr", err_addr[i], 0);
  endtask

  task automatic begin_load(int i, bit rm, logic [63:0] cm);
    rmode[i] = rm;
    corrupt[i] = cm;
    wr_n[i] = 0;
    rd_n[i] = 0;
    done_n[i] = 0;
    done_rel[i] = 0;
    exp_err[i] = 1'b0;
    exp_ea[i] = 6'd0;
    if (i == 1)
      for (int k = 63; k >= 0; k--)
        if (cm[k]) begin
          exp_err[i] = 1'b1;
          exp_ea[i] = 6'(k);
        end
    start[i] = 1'b1;
    @(posedge clk);
    #1;
    start[i] = 1'b0;
    s[i] = ncyc + 1;
    act[i] = 1'b1;
  endtask

  task automatic wait_done(int i, int want_rel, bit poke);
    int rel;
    for (int k = 0; k < 400 && act[i]; k++) begin
      @(negedge clk);
      #1;
      rel = ncyc - s[i] + 1;
      start[i] = poke && (rel == 9 || rel == 69);
    end
    start[i] = 1'b0;
    chk(i, "load finished", act[i], 0);
    act[i] = 1'b0;
    repeat (4) @(negedge clk);
    chk(i, "done pulses", done_n[i], 1);
    chk(i, "write count", wr_n[i], 64);
    chk(i, "read count", rd_n[i], i == 1 ? 64 : 0);
    if (want_rel > 0) chk(i, "done cycle", done_rel[i], want_rel);
    chk(i, "error", error[i], exp_err[i]);
    chk(i, "err_addr", err_addr[i], exp_ea[i]);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) start[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    check_idle(0);
    check_idle(1);
    begin_load(0, 1'b0, 64'd0);
    wait_done(0, 65, 1'b0);
    begin_load(0, 1'b1, 64'd0);
    wait_done(0, -1, 1'b0);
    begin_load(1, 1'b0, 64'd0);
    wait_done(1, 130, 1'b0);
    begin_load(1, 1'b0, (64'd1 << 8'h12) | (64'd1 << 8'h30));
    wait_done(1, 130, 1'b0);
    chk(1, "first mismatch addr", err_addr[1], 6'h12);
    begin_load(1, 1'b0, 64'd0);
    wait_done(1, 130, 1'b1);
    begin_load(1, 1'b0, 64'd0);
    for (int k = 0; k < 100 && !(we[1] && addr[1] == 6'd20); k++) begin
      @(negedge clk);
      #1;
    end
    chk(1, "reached addr 20", addr[1], 20);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    act[1] = 1'b0;
    @(negedge clk);
    #1;
    check_idle(1);
    check_idle(0);
    begin_load(1, 1'b0, 64'd0);
    wait_done(1, 130, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
